// File: rtl/toggle_hs_rx.sv
// Receive side of a two-phase toggle request/acknowledge link with a valid/ready output.
// Optional accepted-event counter is built only when TOGGLE_RX_CNT_EN is defined.
module toggle_hs_rx #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_t,
    input  logic [DW-1:0]    req_data,
    output logic             ack_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        CAPT,
        HOLD
    } state_e;

    state_e                 stateQ;
    logic [SYNC_STAGES-1:0] syncQ;
    logic                   reqPrevQ;
    logic                   ackQ;
    logic                   validQ;
    logic                   errQ;
    logic [DW-1:0]          dataQ;
    logic                   reqS;
    logic                   tog;

    assign reqS = syncQ[SYNC_STAGES-1];
    assign tog  = reqS ^ reqPrevQ;

    // req_t is asynchronous to clk, so it only enters the logic through this chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syncQ <= '0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], req_t};
        end
    end

    // A parity difference left over after a violation is served as a fresh event from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ   <= IDLE;
            reqPrevQ <= 1'b0;
            ackQ     <= 1'b0;
            validQ   <= 1'b0;
            errQ     <= 1'b0;
            dataQ    <= '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (tog) begin
                        reqPrevQ <= reqS;
                        stateQ   <= CAPT;
                    end
                end
                CAPT: begin
                    dataQ  <= req_data;
                    validQ <= 1'b1;
                    stateQ <= HOLD;
                    if (tog) begin
                        errQ <= 1'b1;
                    end
                end
                HOLD: begin
                    if (tog) begin
                        errQ <= 1'b1;
                    end
                    if (out_ready) begin
                        validQ <= 1'b0;
                        ackQ   <= ~ackQ;
                        stateQ <= IDLE;
                    end
                end
                default: begin
                    stateQ <= IDLE;
                end
            endcase
        end
    end

    assign ack_t     = ackQ;
    assign out_valid = validQ;
    assign out_data  = dataQ;
    assign err       = errQ;

`ifdef TOGGLE_RX_CNT_EN
    logic [CNT_W-1:0] cntQ;
    logic [CNT_W-1:0] cntD;

    // Counts accepts only; wraps silently at full scale.
    always_comb begin
        cntD = cntQ;
        if (stateQ == HOLD && out_ready) begin
            cntD = cntQ + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign evt_cnt = cntQ;
`else
    assign evt_cnt = '0;
`endif

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Directed self-checking bench for toggle_hs_rx; the bench plays the toggle sender.
// Counter expectations follow TOGGLE_RX_CNT_EN so the bench suits either build.
module tb_toggle_hs_rx;

    localparam int DW    = 8;
    localparam int SYNC  = 2;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             req_t;
    logic [DW-1:0]    req_data;
    logic             ack_t;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic [CNT_W-1:0] evt_cnt;
    logic             err;

    int               vecCount  = 0;
    int               missCount = 0;
    logic             expAck    = 1'b0;
    logic [CNT_W-1:0] expCnt    = '0;

    toggle_hs_rx #(
        .DW(DW),
        .SYNC_STAGES(SYNC),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_t(req_t),
        .req_data(req_data),
        .ack_t(ack_t),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .evt_cnt(evt_cnt),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge: the sender presents data and toggles its request.
    task automatic applyStimulus(input logic [DW-1:0] data);
        req_data = data;
        req_t    = ~req_t;
    endtask

    task automatic bumpCnt();
`ifdef TOGGLE_RX_CNT_EN
        expCnt = expCnt + CNT_W'(1);
`endif
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(out_valid), 64'd1);
    endtask

    task automatic waitAck(input string tag);
        int n = 0;
        while (ack_t !== expAck && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(ack_t), 64'(expAck));
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_ack"}, 64'(ack_t), 64'(expAck));
        checkOutput({tag, "_cnt"}, 64'(evt_cnt), 64'(expCnt));
    endtask

    initial begin
        rst       = 1'b1;
        req_t     = 1'b0;
        req_data  = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("por_valid", 64'(out_valid), 64'd0);
        checkOutput("por_data", 64'(out_data), 64'd0);
        checkOutput("por_err", 64'(err), 64'd0);
        checkCounters("por");
        rst = 1'b0;
        @(negedge clk);

        // Single event with exact latency: E0 is the first rising edge after the toggle.
        out_ready = 1'b1;
        applyStimulus(8'hA5);
        repeat (SYNC + 1) @(negedge clk);
        checkOutput("lat_early_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("lat_valid", 64'(out_valid), 64'd1);
        checkOutput("lat_data", 64'(out_data), 64'hA5);
        checkOutput("lat_ack_before", 64'(ack_t), 64'd0);
        @(negedge clk);
        expAck = ~expAck;
        bumpCnt();
        checkOutput("single_valid_drop", 64'(out_valid), 64'd0);
        checkCounters("single");

        // Backpressure: ten stalled cycles with everything held.
        out_ready = 1'b0;
        applyStimulus(8'hA5);
        waitValid("bp_valid_wait");
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_hold_data", 64'(out_data), 64'hA5);
            checkOutput("bp_hold_ack", 64'(ack_t), 64'(expAck));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        expAck = ~expAck;
        bumpCnt();
        checkOutput("bp_accept_valid", 64'(out_valid), 64'd0);
        checkCounters("bp_accept");

        // Three events in order, sender waits for each ack toggle.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(DW'(i));
            waitValid("seq_valid_wait");
            checkOutput("seq_data", 64'(out_data), 64'(i));
            expAck = ~expAck;
            bumpCnt();
            waitAck("seq_ack_wait");
        end
        @(negedge clk);
        checkOutput("seq_ack_end", 64'(ack_t), 64'd1);
        checkOutput("seq_err", 64'(err), 64'd0);
        checkCounters("seq_end");

        // Protocol violation: second toggle while the first event is still held.
        out_ready = 1'b0;
        applyStimulus(8'h11);
        waitValid("viol_valid_wait");
        applyStimulus(8'h22);
        repeat (SYNC + 1) @(negedge clk);
        checkOutput("viol_err", 64'(err), 64'd1);
        checkOutput("viol_hold_valid", 64'(out_valid), 64'd1);
        checkOutput("viol_hold_data", 64'(out_data), 64'h11);
        out_ready = 1'b1;
        @(negedge clk);
        expAck = ~expAck;
        bumpCnt();
        checkOutput("viol_first_drop", 64'(out_valid), 64'd0);
        checkCounters("viol_first");
        waitValid("viol_second_wait");
        checkOutput("viol_second_data", 64'(out_data), 64'h22);
        expAck = ~expAck;
        bumpCnt();
        waitAck("viol_second_ack");
        @(negedge clk);
        checkOutput("viol_err_sticky", 64'(err), 64'd1);
        checkCounters("viol_end");

        // Reset mid-stream: outputs clear without any clock edge.
        out_ready = 1'b0;
        applyStimulus(8'h77);
        waitValid("rst_valid_wait");
        rst = 1'b1;
        #1;
        expAck = 1'b0;
        expCnt = '0;
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_data", 64'(out_data), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkCounters("rst");
        req_t    = 1'b0;
        req_data = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Counter wrap at 2^CNT_W accepted events.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(DW'(8'h40 + i));
            waitValid("wrap_valid_wait");
            checkOutput("wrap_data", 64'(out_data), 64'(8'h40 + i));
            expAck = ~expAck;
            bumpCnt();
            waitAck("wrap_ack_wait");
            if (i == 14) begin
                checkOutput("wrap_cnt_15", 64'(evt_cnt), 64'(expCnt));
            end
        end
        @(negedge clk);
        checkOutput("wrap_cnt_zero", 64'(evt_cnt), 64'd0);
        checkOutput("wrap_err", 64'(err), 64'd0);
        checkOutput("wrap_valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
